elastic_pe_ctx: RTL

- Parametrised context-sequenced elastic processing element for the elastic CGRA fabric.
- NEIGHBOR_NUM SELF-protocol input channels are each buffered by a per-port FIFO. Each firing selects two operands per the current context, executes one ALU op, and eagerly forks the result to a per-context subset of neighbor outputs.
- Adds over the previous PE: configurable FIFO depth, per-context output mask carried with each token, own-result feedback source, and an IDLE/RUN/DRAIN controller.

---
 rtl/elastic_pe_ctx.sv | 313 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/elastic_pe_ctx.sv
// -----------------------------------------------------------------------------
// elastic_pe_ctx
//
// Context-sequenced elastic processing element for the elastic CGRA fabric.
// Every neighbor input channel is buffered by its own small FIFO. On each
// firing the PE looks up the current context, picks two operands, runs one
// ALU operation and eagerly forks the result to the neighbor outputs that
// the context enables. An IDLE/RUN/DRAIN controller gates the firings.
//
// Ports
//   clk, reset_n    clock, asynchronous active-low reset
//   cfg_*           context memory write port (one entry per cfg_write)
//   start_exec      enter RUN from any state: ctx_id=0, FIFOs and output
//                   stage flushed
//   stop_exec       RUN -> DRAIN; DRAIN returns to IDLE once the output
//                   stage has emptied
//   ctx_max_id      last context index before ctx_id wraps to 0
//   in_data/in_valid/in_stop     NEIGHBOR_NUM input channels (flat data bus)
//   out_data/out_valid/out_stop  result broadcast plus per-channel handshake
//   ctx_id, state   current context index and controller state
//                   (0=IDLE, 1=RUN, 2=DRAIN)
// -----------------------------------------------------------------------------
module elastic_pe_ctx #(
    parameter int DATA_WIDTH    = 32,
    parameter int NEIGHBOR_NUM  = 4,
    parameter int CONTEXT_DEPTH = 8,
    parameter int IN_FIFO_DEPTH = 2,
    localparam int CTX_W        = $clog2(CONTEXT_DEPTH),
    localparam int SEL_W        = $clog2(NEIGHBOR_NUM + 2)
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               cfg_write,
    input  logic [CTX_W-1:0]                   cfg_index,
    input  logic [SEL_W-1:0]                   cfg_src_a,
    input  logic [SEL_W-1:0]                   cfg_src_b,
    input  logic [NEIGHBOR_NUM-1:0]            cfg_out_mask,
    input  logic [2:0]                         cfg_op,
    input  logic [DATA_WIDTH-1:0]              cfg_const,
    input  logic                               start_exec,
    input  logic                               stop_exec,
    input  logic [CTX_W-1:0]                   ctx_max_id,
    input  logic [NEIGHBOR_NUM*DATA_WIDTH-1:0] in_data,
    input  logic [NEIGHBOR_NUM-1:0]            in_valid,
    output logic [NEIGHBOR_NUM-1:0]            in_stop,
    output logic [DATA_WIDTH-1:0]              out_data,
    output logic [NEIGHBOR_NUM-1:0]            out_valid,
    input  logic [NEIGHBOR_NUM-1:0]            out_stop,
    output logic [CTX_W-1:0]                   ctx_id,
    output logic [1:0]                         state
);

    localparam int PTR_W = $clog2(IN_FIFO_DEPTH);

    // Operand-select codes beyond the FIFO channels.
    localparam logic [SEL_W-1:0] SEL_CONST = SEL_W'(NEIGHBOR_NUM);
    localparam logic [SEL_W-1:0] SEL_SELF  = SEL_W'(NEIGHBOR_NUM + 1);
    localparam logic [CTX_W-1:0] CTX_LAST  = CTX_W'(CONTEXT_DEPTH - 1);

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_MUL  = 3'd2;
    localparam logic [2:0] OP_AND  = 3'd3;
    localparam logic [2:0] OP_OR   = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_PASS = 3'd6;
    localparam logic [2:0] OP_LT   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [SEL_W-1:0]        src_a;
        logic [SEL_W-1:0]        src_b;
        logic [NEIGHBOR_NUM-1:0] out_mask;
        logic [2:0]              op;
        logic [DATA_WIDTH-1:0]   const_val;
    } cfg_t;

    // -------------------------------------------------------------------------
    // Registered state
    // -------------------------------------------------------------------------
    state_t                  state_reg;
    logic [CTX_W-1:0]        ctx_id_reg;
    logic [NEIGHBOR_NUM-1:0] pending_reg;
    logic [DATA_WIDTH-1:0]   out_data_reg;
    logic [DATA_WIDTH-1:0]   self_reg;

    // -------------------------------------------------------------------------
    // Context memory. Held in flops rather than block RAM: it must clear on
    // reset and is read in the same cycle as the firing decision, so a write
    // to the live context takes effect from the following cycle.
    // -------------------------------------------------------------------------
    cfg_t cfg_mem [CONTEXT_DEPTH];
    cfg_t cur_cfg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CONTEXT_DEPTH; i++) begin
                cfg_mem[i] <= '0;
            end
        end else if (cfg_write) begin
            cfg_mem[cfg_index] <= '{src_a:     cfg_src_a,
                                    src_b:     cfg_src_b,
                                    out_mask:  cfg_out_mask,
                                    op:        cfg_op,
                                    const_val: cfg_const};
        end
    end

    assign cur_cfg = cfg_mem[ctx_id_reg];

    // -------------------------------------------------------------------------
    // Per-channel input FIFOs
    // -------------------------------------------------------------------------
    logic [NEIGHBOR_NUM-1:0] fifo_full;
    logic [NEIGHBOR_NUM-1:0] fifo_empty;
    logic [NEIGHBOR_NUM-1:0] fifo_push;
    logic [NEIGHBOR_NUM-1:0] fifo_pop;
    logic [DATA_WIDTH-1:0]   fifo_head [NEIGHBOR_NUM];

    genvar gi;
    generate
        for (gi = 0; gi < NEIGHBOR_NUM; gi++) begin : g_fifo
            logic [DATA_WIDTH-1:0] mem [IN_FIFO_DEPTH];
            logic [PTR_W-1:0]      wr_ptr_reg;
            logic [PTR_W-1:0]      rd_ptr_reg;
            logic [PTR_W:0]        count_reg;

            assign fifo_full[gi]  = (count_reg == (PTR_W+1)'(IN_FIFO_DEPTH));
            assign fifo_empty[gi] = (count_reg == '0);
            // A restart flushes the FIFO, so a push in that cycle is dropped.
            assign fifo_push[gi]  = in_valid[gi] & ~fifo_full[gi] & ~start_exec;
            assign fifo_head[gi]  = mem[rd_ptr_reg];

            // Payload storage carries no reset; occupancy is tracked by count.
            always_ff @(posedge clk) begin
                if (fifo_push[gi]) begin
                    mem[wr_ptr_reg] <= in_data[gi*DATA_WIDTH +: DATA_WIDTH];
                end
            end

            // Depth is a power of two, so the pointers wrap on overflow.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else if (start_exec) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (fifo_push[gi]) begin
                        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                    end
                    if (fifo_pop[gi]) begin
                        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                    end
                    count_reg <= count_reg
                               + {{PTR_W{1'b0}}, fifo_push[gi]}
                               - {{PTR_W{1'b0}}, fifo_pop[gi]};
                end
            end
        end
    endgenerate

    assign in_stop = fifo_full;

    // -------------------------------------------------------------------------
    // Operand selection
    // -------------------------------------------------------------------------
    logic                    a_ok;
    logic                    b_ok;
    logic [DATA_WIDTH-1:0]   a_val;
    logic [DATA_WIDTH-1:0]   b_val;
    logic [NEIGHBOR_NUM-1:0] hit_a;
    logic [NEIGHBOR_NUM-1:0] hit_b;

    // Unknown select codes leave the operand unavailable, stalling the PE.
    always_comb begin
        a_ok  = 1'b0;
        b_ok  = 1'b0;
        a_val = '0;
        b_val = '0;
        hit_a = '0;
        hit_b = '0;
        for (int i = 0; i < NEIGHBOR_NUM; i++) begin
            if (cur_cfg.src_a == SEL_W'(i)) begin
                hit_a[i] = 1'b1;
                a_ok     = ~fifo_empty[i];
                a_val    = fifo_head[i];
            end
            if (cur_cfg.src_b == SEL_W'(i)) begin
                hit_b[i] = 1'b1;
                b_ok     = ~fifo_empty[i];
                b_val    = fifo_head[i];
            end
        end
        if (cur_cfg.src_a == SEL_CONST) begin
            a_ok  = 1'b1;
            a_val = cur_cfg.const_val;
        end else if (cur_cfg.src_a == SEL_SELF) begin
            a_ok  = 1'b1;
            a_val = self_reg;
        end
        if (cur_cfg.src_b == SEL_CONST) begin
            b_ok  = 1'b1;
            b_val = cur_cfg.const_val;
        end else if (cur_cfg.src_b == SEL_SELF) begin
            b_ok  = 1'b1;
            b_val = self_reg;
        end
    end

    // -------------------------------------------------------------------------
    // ALU
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] alu_result;

    always_comb begin
        alu_result = '0;
        case (cur_cfg.op)
            OP_ADD:  alu_result = a_val + b_val;
            OP_SUB:  alu_result = a_val - b_val;
            OP_MUL:  alu_result = a_val * b_val;
            OP_AND:  alu_result = a_val & b_val;
            OP_OR:   alu_result = a_val | b_val;
            OP_XOR:  alu_result = a_val ^ b_val;
            OP_PASS: alu_result = a_val;
            OP_LT:   alu_result = {{(DATA_WIDTH-1){1'b0}}, (a_val < b_val)};
            default: alu_result = '0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Firing decision
    // -------------------------------------------------------------------------
    // Bits still owed after this cycle's acceptances. The output stage counts
    // as free when nothing remains, which lets a new token replace the old
    // one on the same edge the last channel accepts it (full throughput).
    logic [NEIGHBOR_NUM-1:0] pending_left;
    logic                    out_free;
    logic                    fire;
    logic [CTX_W-1:0]        ctx_next;

    assign pending_left = pending_reg & out_stop;
    assign out_free     = (pending_left == '0);
    assign fire         = (state_reg == ST_RUN) & a_ok & b_ok & out_free & ~start_exec;

    // A shared source is popped once: the OR of the two hit vectors.
    assign fifo_pop = {NEIGHBOR_NUM{fire}} & (hit_a | hit_b);

    assign ctx_next = ((ctx_id_reg >= ctx_max_id) || (ctx_id_reg == CTX_LAST))
                    ? '0 : ctx_id_reg + CTX_W'(1);

    // -------------------------------------------------------------------------
    // Controller, context sequencer and output stage
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            ctx_id_reg   <= '0;
            pending_reg  <= '0;
            out_data_reg <= '0;
            self_reg     <= '0;
        end else if (start_exec) begin
            // Restart wins over stop, fire and push; the self register keeps
            // its value so a program can chain across restarts.
            state_reg   <= ST_RUN;
            ctx_id_reg  <= '0;
            pending_reg <= '0;
        end else begin
            if (fire) begin
                self_reg     <= alu_result;
                out_data_reg <= alu_result;
                pending_reg  <= cur_cfg.out_mask;
                ctx_id_reg   <= ctx_next;
            end else begin
                pending_reg  <= pending_left;
            end

            case (state_reg)
                ST_IDLE: begin
                    state_reg <= ST_IDLE;
                end
                ST_RUN: begin
                    if (stop_exec) begin
                        state_reg <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Leave as soon as the last outstanding channel accepts.
                    if (pending_left == '0) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_data  = out_data_reg;
    assign out_valid = pending_reg;
    assign ctx_id    = ctx_id_reg;
    assign state     = state_reg;

endmodule
